// File: rtl/register_pipeline_pkg.sv
// Shared types for the register pipeline flow controller.
// Holds the controller state encoding and the occupancy-width helper.
package register_pipeline_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE   = 2'd0,
        CTRL_ACTIVE = 2'd1,
        CTRL_DRAIN  = 2'd2
    } ctrl_state_t;

    // Smallest width (at least 1) able to encode n distinct values.
    function automatic int clog2_cnt(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << w) < 64'(n)) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/register_pipeline_ctrl.sv
// Valid/ready to clock-enable controller for a shared-CE register pipeline; latency NUM_STAGES, 1 item/cycle.
// Backpressure: M_VALID & !M_READY freezes every stage (bubbles kept); FLUSH drains, ABORT discards.
module register_pipeline_ctrl
    import register_pipeline_pkg::*;
#(
    parameter int NUM_STAGES = 1,
    parameter int CNT_WIDTH  = clog2_cnt(NUM_STAGES + 1)
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 S_VALID,
    output logic                 S_READY,
    output logic                 M_VALID,
    input  logic                 M_READY,
    output logic                 PIPE_CE,
    input  logic                 FLUSH,
    input  logic                 ABORT,
    output logic                 FLUSH_DONE,
    output logic [CNT_WIDTH-1:0] OCCUPANCY,
    output logic                 BUSY
);

    logic [NUM_STAGES-1:0] vld;
    logic [NUM_STAGES-1:0] vld_shift;
    logic [CNT_WIDTH-1:0]  occ;
    logic [CNT_WIDTH-1:0]  occ_next;
    ctrl_state_t           state;
    ctrl_state_t           state_next;
    logic                  advance;
    logic                  accept;
    logic                  deliver;

    assign M_VALID   = vld[NUM_STAGES-1];
    assign advance   = ~M_VALID | M_READY;
    assign PIPE_CE   = RSTN & advance;
    assign S_READY   = RSTN & advance & (state != CTRL_DRAIN);
    assign accept    = S_VALID & S_READY;
    assign deliver   = M_VALID & M_READY;
    assign OCCUPANCY = occ;
    assign BUSY      = (state != CTRL_IDLE);

    // In DRAIN S_READY is low, so the shifted-in bit is a bubble.
    generate
        if (NUM_STAGES == 1) begin : g_single
            assign vld_shift = accept;
        end else begin : g_chain
            assign vld_shift = {vld[NUM_STAGES-2:0], accept};
        end
    endgenerate

    always_comb begin
        occ_next = occ;
        if (accept && !deliver) begin
            occ_next = occ + CNT_WIDTH'(1);
        end else if (!accept && deliver) begin
            occ_next = occ - CNT_WIDTH'(1);
        end
    end

    // FLUSH_DONE fires in the last DRAIN cycle, so BUSY drops on the following cycle.
    always_comb begin
        state_next = state;
        FLUSH_DONE = 1'b0;
        case (state)
            CTRL_IDLE: begin
                if (FLUSH) begin
                    state_next = CTRL_DRAIN;
                end else if (accept) begin
                    state_next = CTRL_ACTIVE;
                end
            end
            CTRL_ACTIVE: begin
                if (FLUSH) begin
                    state_next = CTRL_DRAIN;
                end else if (occ_next == '0) begin
                    state_next = CTRL_IDLE;
                end
            end
            CTRL_DRAIN: begin
                if (occ_next == '0) begin
                    state_next = CTRL_IDLE;
                    FLUSH_DONE = 1'b1;
                end
            end
            default: begin
                state_next = CTRL_IDLE;
            end
        endcase
        if (ABORT || !RSTN) begin
            state_next = CTRL_IDLE;
            FLUSH_DONE = 1'b0;
        end
    end

    // ABORT clears control state only; stale datapath contents are masked by M_VALID.
    always_ff @(posedge CLK) begin
        if (!RSTN || ABORT) begin
            vld   <= '0;
            occ   <= '0;
            state <= CTRL_IDLE;
        end else begin
            if (advance) begin
                vld <= vld_shift;
            end
            occ   <= occ_next;
            state <= state_next;
        end
    end

endmodule

// File: tb/tb_register_pipeline_ctrl.sv
// Randomised scoreboard bench for register_pipeline_ctrl with a stand-in datapath driven by PIPE_CE.
module tb_register_pipeline_ctrl;
    import register_pipeline_pkg::*;

    localparam int N  = 4;
    localparam int CW = clog2_cnt(N + 1);

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          S_VALID = 1'b0;
    logic          M_READY = 1'b0;
    logic          FLUSH = 1'b0;
    logic          ABORT = 1'b0;
    logic          S_READY;
    logic          M_VALID;
    logic          PIPE_CE;
    logic          FLUSH_DONE;
    logic          BUSY;
    logic [CW-1:0] OCCUPANCY;

    logic [15:0] data_in = 16'd0;
    logic [15:0] dpipe [N];

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: each in-flight item remembers the advance-cycle index at which it entered;
    // it reaches the output once N further advances have happened.
    int          items[$];
    logic [15:0] sb_q[$];
    int          adv_cnt = 0;
    bit          draining = 1'b0;

    always #5 CLK = ~CLK;

    register_pipeline_ctrl #(.NUM_STAGES(N)) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .S_VALID    (S_VALID),
        .S_READY    (S_READY),
        .M_VALID    (M_VALID),
        .M_READY    (M_READY),
        .PIPE_CE    (PIPE_CE),
        .FLUSH      (FLUSH),
        .ABORT      (ABORT),
        .FLUSH_DONE (FLUSH_DONE),
        .OCCUPANCY  (OCCUPANCY),
        .BUSY       (BUSY)
    );

    always @(posedge CLK) begin
        if (PIPE_CE) begin
            dpipe[0] <= data_in;
            for (int i = 1; i < N; i++) dpipe[i] <= dpipe[i-1];
        end
    end

    function automatic bit exp_mvalid();
        return (items.size() > 0) && (adv_cnt >= items[0] + N);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle control output check against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            bit mv, adv, sr, fire, acc;
            int nsz;
            mv   = exp_mvalid();
            adv  = !mv || M_READY;
            sr   = RSTN && adv && !draining;
            fire = mv && M_READY;
            acc  = S_VALID && sr;
            nsz  = items.size() + int'(acc) - int'(fire);
            check("m_valid",    32'(M_VALID),    32'(mv));
            check("pipe_ce",    32'(PIPE_CE),    32'(RSTN && adv));
            check("s_ready",    32'(S_READY),    32'(sr));
            check("occupancy",  32'(OCCUPANCY),  32'(items.size()));
            check("busy",       32'(BUSY),       32'(draining || items.size() > 0));
            check("flush_done", 32'(FLUSH_DONE), 32'(RSTN && !ABORT && draining && nsz == 0));
        end
    end

    // Output data monitor: pops the scoreboard on every downstream transfer.
    always @(negedge CLK) begin
        if (chk_en && M_VALID === 1'b1 && M_READY) begin
            logic [15:0] e;
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL data_out: got %0d with no item expected at %0t", dpipe[N-1], $time);
            end else begin
                e = sb_q.pop_front();
                check("data_out", 32'(dpipe[N-1]), 32'(e));
            end
        end
    end

    // Model state update at the clock edge, from the pre-edge inputs.
    always @(posedge CLK) begin
        bit mv, adv, sr, fire, acc;
        int nsz;
        mv   = exp_mvalid();
        adv  = !mv || M_READY;
        sr   = RSTN && adv && !draining;
        fire = mv && M_READY;
        acc  = S_VALID && sr;
        nsz  = items.size() + int'(acc) - int'(fire);
        if (!RSTN || ABORT) begin
            items.delete();
            sb_q.delete();
            draining = 1'b0;
        end else begin
            if (fire) void'(items.pop_front());
            if (acc) begin
                items.push_back(adv_cnt);
                sb_q.push_back(data_in);
            end
            if (draining) begin
                if (nsz == 0) draining = 1'b0;
            end else if (FLUSH) begin
                draining = 1'b1;
            end
            if (adv) adv_cnt++;
        end
    end

    task automatic drive(input bit sv, input bit mr, input bit fl, input bit ab, input bit rn);
        @(posedge CLK);
        #1;
        S_VALID = sv;
        M_READY = mr;
        FLUSH   = fl;
        ABORT   = ab;
        RSTN    = rn;
        data_in = data_in + 16'd1;
    endtask

    initial begin
        int bias;
        repeat (2) drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1);
        chk_en = 1'b1;
        drive(0, 1, 0, 0, 1);

        // Streaming with no backpressure, then a full-pipe stall.
        repeat (12) drive(1, 1, 0, 0, 1);
        repeat (6)  drive(1, 0, 0, 0, 1);
        repeat (3)  drive(0, 1, 0, 0, 1);
        repeat (4)  drive(0, 1, 0, 0, 1);

        // Items with a bubble, then FLUSH while upstream keeps offering.
        drive(1, 1, 0, 0, 1);
        drive(0, 1, 0, 0, 1);
        drive(1, 1, 0, 0, 1);
        drive(1, 1, 1, 0, 1);
        repeat (7) drive(1, 1, 0, 0, 1);
        repeat (5) drive(0, 1, 0, 0, 1);

        // FLUSH while idle, and a repeated FLUSH during drain.
        drive(0, 1, 1, 0, 1);
        repeat (3) drive(0, 1, 0, 0, 1);
        drive(1, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 1);
        repeat (8) drive(0, 1, 0, 0, 1);

        // ABORT with three items in flight, then restart.
        repeat (3) drive(1, 1, 0, 0, 1);
        drive(1, 1, 0, 1, 1);
        drive(1, 1, 0, 0, 1);
        repeat (8) drive(0, 1, 0, 0, 1);

        // Mid-stream reset for one cycle.
        repeat (5) drive(1, 1, 0, 0, 1);
        drive(1, 1, 0, 0, 0);
        repeat (6) drive(1, 1, 0, 0, 1);

        // Randomised traffic with varying downstream pressure.
        bias = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) bias = $urandom_range(0, 3);
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) >= bias,
                  $urandom_range(0, 40) == 0,
                  $urandom_range(0, 60) == 0,
                  $urandom_range(0, 250) != 0);
        end

        repeat (12) drive(0, 1, 0, 0, 1);
        @(negedge CLK);
        #1;
        check("drained_scoreboard", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
